// File: rtl/timer_array.sv
// Array of NCH Avalon-MM programmable down-counters with per-channel interrupts; readdata latency 1, no wait states.
// Optional per-channel 8-bit tick prescaler is compiled in with TIMER_PRESCALE_EN.
module timer_array #(
   parameter int NCH        = 4,
   parameter int CNT_W      = 32,
   parameter int PERIOD_RST = 499999
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [$clog2(NCH)+1:0] address,
   input  logic                   chipselect,
   input  logic                   write_n,
   input  logic [31:0]            writedata,
   output logic [31:0]            readdata,
   output logic [NCH-1:0]         irq_vec,
   output logic                   irq
);
   localparam int               AW        = $clog2(NCH) + 2;
   localparam logic [CNT_W-1:0] P_RST     = CNT_W'(PERIOD_RST);
   localparam logic [1:0]       R_STATUS  = 2'd0;
   localparam logic [1:0]       R_CONTROL = 2'd1;
   localparam logic [1:0]       R_PERIOD  = 2'd2;

   logic [CNT_W-1:0] counter  [NCH];
   logic [CNT_W-1:0] period   [NCH];
   logic [CNT_W-1:0] snapshot [NCH];
   logic [NCH-1:0]   run, to, ito, cont, last_nz, per_pend;
   logic [NCH-1:0]   tick, evt, sel;
   logic [AW-1:0]    a_ch;
   logic [1:0]       a_reg;
   logic             wr;
   logic [31:0]      rd_mux;
`ifdef TIMER_PRESCALE_EN
   logic [7:0]       prescale [NCH];
   logic [7:0]       pdiv     [NCH];
`endif

   assign a_ch  = address >> 2;
   assign a_reg = address[1:0];
   assign wr    = chipselect & ~write_n;

   // A timeout is the counter sitting at 0 after being non-zero the cycle before.
   always_comb begin
      sel  = '0;
      tick = '0;
      evt  = '0;
      for (int i = 0; i < NCH; i++) begin
         sel[i]  = (a_ch == AW'(i));
`ifdef TIMER_PRESCALE_EN
         tick[i] = run[i] & (pdiv[i] == prescale[i]);
`else
         tick[i] = run[i];
`endif
         evt[i]  = (counter[i] == '0) & last_nz[i];
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NCH; i++) begin
         if (sel[i]) begin
            case (a_reg)
               R_STATUS:  rd_mux = {30'b0, run[i], to[i]};
               R_CONTROL: begin
                  rd_mux[1:0] = {cont[i], ito[i]};
`ifdef TIMER_PRESCALE_EN
                  rd_mux[15:8] = prescale[i];
`endif
               end
               R_PERIOD:  rd_mux = 32'(period[i]);
               default:   rd_mux = 32'(snapshot[i]);
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         readdata <= '0;
         run      <= '0;
         to       <= '0;
         ito      <= '0;
         cont     <= '0;
         last_nz  <= '0;
         per_pend <= '0;
         for (int i = 0; i < NCH; i++) begin
            counter[i]  <= P_RST;
            period[i]   <= P_RST;
            snapshot[i] <= '0;
`ifdef TIMER_PRESCALE_EN
            prescale[i] <= '0;
            pdiv[i]     <= '0;
`endif
         end
      end else begin
         readdata <= rd_mux;
         for (int i = 0; i < NCH; i++) begin
            last_nz[i]  <= (counter[i] != '0);
            per_pend[i] <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            if (run[i])
               pdiv[i] <= (pdiv[i] == prescale[i]) ? 8'd0 : pdiv[i] + 8'd1;
`endif
            if (tick[i]) begin
               if (counter[i] == '0) begin
                  counter[i] <= period[i];
                  if (!cont[i])
                     run[i] <= 1'b0;
               end else begin
                  counter[i] <= counter[i] - CNT_W'(1);
               end
            end

            // A pending STATUS clear never swallows a timeout landing on the same edge.
            if (evt[i])
               to[i] <= 1'b1;
            else if (wr && sel[i] && a_reg == R_STATUS)
               to[i] <= 1'b0;

            // Deferred half of a PERIOD write; a bus write on this edge still overrides it.
            if (per_pend[i]) begin
               run[i]     <= 1'b0;
               counter[i] <= period[i];
            end

            if (wr && sel[i]) begin
               case (a_reg)
                  R_CONTROL: begin
                     ito[i]  <= writedata[0];
                     cont[i] <= writedata[1];
`ifdef TIMER_PRESCALE_EN
                     prescale[i] <= writedata[15:8];
`endif
                     if (writedata[2]) begin
                        run[i] <= 1'b1;
`ifdef TIMER_PRESCALE_EN
                        pdiv[i] <= '0;
`endif
                     end else if (writedata[3]) begin
                        run[i] <= 1'b0;
                     end
                  end
                  R_PERIOD: begin
                     period[i]   <= writedata[CNT_W-1:0];
                     per_pend[i] <= 1'b1;
`ifdef TIMER_PRESCALE_EN
                     pdiv[i]     <= '0;
`endif
                  end
                  R_STATUS: ;
                  default:  snapshot[i] <= counter[i];
               endcase
            end
         end
      end
   end

   assign irq_vec = to & ito;
   assign irq     = |irq_vec;

endmodule

// File: tb/tb_timer_array.sv
// Self-checking bench for timer_array: reset-value table, directed corner sequences, randomized runs vs closed-form model.
module tb_timer_array;
   localparam int NCH = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [3:0]  irq_vec;
   logic        irq;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   timer_array #(.NCH(NCH), .CNT_W(32), .PERIOD_RST(499999)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .irq_vec(irq_vec), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          ch;
      int          rg;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [16];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   task automatic bus_wr(input int ch, input int rg, input logic [31:0] d, output int e);
      @(negedge clk);
      address = 4'(ch * 4 + rg); chipselect = 1'b1; write_n = 1'b0; writedata = d;
      @(posedge clk); #1;
      e = cyc; chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_rd(input int ch, input int rg, output logic [31:0] d, output int e);
      @(negedge clk);
      address = 4'(ch * 4 + rg); chipselect = 1'b1; write_n = 1'b1;
      @(posedge clk); #1;
      d = readdata; e = cyc; chipselect = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); reset_n = 1'b0;
      @(posedge clk); #1;
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_irq_vec", 32'(irq_vec), 32'h0);
      check("rst_readdata", readdata, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic run_table();
      logic [31:0] d;
      int e;
      for (int i = 0; i < 16; i++) begin
         bus_rd(tbl[i].ch, tbl[i].rg, d, e);
         check($sformatf("tbl_ch%0d_r%0d", tbl[i].ch, tbl[i].rg), d, tbl[i].exp);
      end
   endtask

   // Started at edge s with counter=p: value after edge s+k.
   function automatic logic [31:0] m_cnt(int p, bit per, int k);
      if (!per && k > p) return 32'(p);
      return 32'(p - (k % (p + 1)));
   endfunction
   function automatic bit m_to(int p, int k);
      return k >= p + 1;
   endfunction
   function automatic bit m_run(int p, bit per, int k);
      return per || (k < p + 1);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int e0, s, e, w, r, x, first, second;
      int ch, p, n;
      bit per, ie;
      logic [31:0] frozen;

      for (int c = 0; c < 4; c++) begin
         tbl[c*4+0] = '{c, 0, 32'h0};
         tbl[c*4+1] = '{c, 1, 32'h0};
         tbl[c*4+2] = '{c, 2, 32'd499999};
         tbl[c*4+3] = '{c, 3, 32'h0};
      end

      do_reset();
      run_table();

      // Periodic: first irq 11 edges after PERIOD write, then every 10.
      bus_wr(0, 2, 32'd9, e0);
      bus_wr(0, 1, 32'h7, s);
      first = -1;
      for (int c = 0; c < 40 && first < 0; c++) begin
         @(posedge clk); #1;
         if (irq_vec[0]) first = cyc;
      end
      check("per_first_rise", 32'(first - e0), 32'd11);
      bus_wr(0, 0, 32'h0, e);
      check("per_to_cleared", 32'(irq_vec[0]), 32'h0);
      second = -1;
      for (int c = 0; c < 40 && second < 0; c++) begin
         @(posedge clk); #1;
         if (irq_vec[0]) second = cyc;
      end
      check("per_repeat", 32'(second - first), 32'd10);
      bus_rd(0, 0, d, e);
      check("per_status", d, 32'h3);
      bus_wr(0, 1, 32'h8, e);
      bus_wr(0, 0, 32'h0, e);

      // One-shot on ch2.
      bus_wr(2, 2, 32'd4, e);
      bus_wr(2, 1, 32'h5, s);
      repeat (20) @(posedge clk);
      bus_rd(2, 0, d, e);
      check("os_status", d, 32'h1);
      bus_wr(2, 3, 32'h0, e);
      bus_rd(2, 3, d, e);
      check("os_counter_held", d, 32'd4);
      check("os_irq", 32'(irq), 32'h1);
      bus_wr(2, 0, 32'h0, e);
      check("os_irq_vec_clr", 32'(irq_vec[2]), 32'h0);
      check("os_irq_clr", 32'(irq), 32'h0);

      // START+STOP together, then STOP freezes the counter.
      bus_wr(1, 2, 32'd100, e);
      bus_wr(1, 1, 32'h4, s);
      repeat (5) @(posedge clk);
      bus_wr(1, 1, 32'hC, e);
      bus_rd(1, 0, d, e);
      check("ss_start_wins", d, 32'h2);
      bus_wr(1, 1, 32'h8, x);
      repeat (3) @(posedge clk);
      bus_wr(1, 3, 32'h0, e);
      bus_rd(1, 3, d, e);
      frozen = d;
      check("stop_snap", d, 32'(100 - (x - s)));
      bus_rd(1, 0, d, e);
      check("stop_status", d, 32'h0);
      repeat (4) @(posedge clk);
      bus_wr(1, 3, 32'h0, e);
      bus_rd(1, 3, d, e);
      check("stop_frozen", d, frozen);

      // STATUS clear on the same edge as the timeout: timeout wins.
      bus_wr(3, 2, 32'd5, e);
      bus_wr(3, 1, 32'h5, s);
      repeat (5) @(posedge clk);
      bus_wr(3, 0, 32'h0, e);
      check("race_irq_vec", 32'(irq_vec[3]), 32'h1);
      check("race_irq", 32'(irq), 32'h1);
      bus_rd(3, 0, d, e);
      check("race_status", d, 32'h1);
      bus_wr(3, 0, 32'h0, e);
      check("race_later_clear", 32'(irq_vec[3]), 32'h0);

      // CONTROL readback of prescale field.
      bus_wr(2, 1, 32'h0306, e);
      bus_rd(2, 1, d, e);
`ifdef TIMER_PRESCALE_EN
      check("ctrl_readback", d, 32'h0302);
      bus_wr(1, 2, 32'd50, e);
      bus_wr(1, 1, 32'h0304, s);
      repeat (9) @(posedge clk);
      bus_wr(1, 3, 32'h0, w);
      bus_rd(1, 3, d, e);
      check("presc_cadence", d, 32'(50 - (w - 1 - s) / 4));
`else
      check("ctrl_readback", d, 32'h0002);
`endif

      // Randomized runs against the closed-form model.
      for (int it = 0; it < 40; it++) begin
         ch  = $urandom_range(0, 3);
         p   = $urandom_range(1, 12);
         per = 1'($urandom_range(0, 1));
         ie  = 1'($urandom_range(0, 1));
         n   = $urandom_range(0, 30);
         bus_wr(ch, 2, 32'(p), e0);
         bus_wr(ch, 1, 32'h4 | (per ? 32'h2 : 32'h0) | (ie ? 32'h1 : 32'h0), s);
         bus_wr(ch, 0, 32'h0, e);
         repeat (n) @(posedge clk);
         bus_wr(ch, 3, 32'h0, w);
         bus_rd(ch, 3, d, e);
         check($sformatf("rnd%0d_snap", it), d, m_cnt(p, per, w - 1 - s));
         bus_rd(ch, 0, d, r);
         check($sformatf("rnd%0d_status", it), d,
               {30'b0, m_run(p, per, r - 1 - s), m_to(p, r - 1 - s)});
         check($sformatf("rnd%0d_irq", it), 32'(irq_vec[ch]), 32'(m_to(p, r - s) & ie));
      end

      // Reset in the middle of counting abandons everything.
      bus_wr(0, 2, 32'd3, e);
      bus_wr(0, 1, 32'h7, e);
      repeat (2) @(posedge clk);
      do_reset();
      repeat (6) @(posedge clk);
      check("post_rst_irq", 32'(irq), 32'h0);
      run_table();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
